// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared types and constants for count_period_monitor.
package count_mon_pkg;

    localparam int unsigned DEF_PERIOD_W = 12;

    // Saturation ceiling of a default-width period measurement.
    localparam logic [DEF_PERIOD_W-1:0] PERIOD_MAX = '1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One period record as held in the FIFO and presented downstream.
    typedef struct packed {
        logic [DEF_PERIOD_W-1:0] period;
        logic                    sat;
    } rec_t;

endpackage

// File: rtl/count_mon_fifo.sv
// count_mon_fifo: small synchronous FIFO for period records.
// The head entry is driven straight from the storage flops; no fall-through.
module count_mon_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign dout  = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/count_period_monitor.sv
// count_period_monitor: detects wraps of an upstream counter, measures the
// wrap period in enabled cycles and queues period records for downstream.
// Optional min/max period outputs: define COUNT_PERIOD_MONITOR_STATS_EN.
module count_period_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned PERIOD_W   = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [COUNT_W-1:0]  count_in,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [PERIOD_W-1:0] rec_period,
    output logic                rec_sat,
    output logic                locked,
    output logic                overflow
`ifdef COUNT_PERIOD_MONITOR_STATS_EN
    ,
    output logic [PERIOD_W-1:0] min_period,
    output logic [PERIOD_W-1:0] max_period
`endif
);
    localparam logic [PERIOD_W-1:0] PMAX  = '1;
    localparam int unsigned         REC_W = PERIOD_W + 1;

    logic [COUNT_W-1:0]  prev_count;
    logic                primed;
    logic                wrap_q;
    logic                step_q;
    state_e              state_q;
    state_e              state_d;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_d;
    logic                sat_q;
    logic                sat_d;
    logic                push;
    logic                lock_set;
    logic                locked_q;
    logic                overflow_q;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [REC_W-1:0]    head;

    // Input compare stage: wrap flag and enable are registered together so the
    // measurement stage counts exactly the enabled cycles the compare saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_count <= '0;
            primed     <= 1'b0;
            wrap_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            if (en) begin
                prev_count <= count_in;
            end
            primed <= en;
            wrap_q <= en && primed && (count_in < prev_count);
            step_q <= en;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave SYNC on the first wrap.
    always_comb begin
        state_d = state_q;
        if (state_q == SYNC && step_q && wrap_q) begin
            state_d = RUN;
        end
    end

    // Measurement datapath and record push per state.
    always_comb begin
        period_d = period_q;
        sat_d    = sat_q;
        push     = 1'b0;
        lock_set = 1'b0;
        unique case (state_q)
            SYNC: begin
                period_d = '0;
                sat_d    = 1'b0;
                if (step_q && wrap_q) begin
                    period_d = PERIOD_W'(1);
                    lock_set = 1'b1;
                end
            end
            RUN: begin
                if (step_q) begin
                    if (wrap_q) begin
                        push     = 1'b1;
                        period_d = PERIOD_W'(1);
                        sat_d    = 1'b0;
                    end else if (period_q == PMAX) begin
                        sat_d = 1'b1;
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Period counter, saturation flag and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q   <= '0;
            sat_q      <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            period_q <= period_d;
            sat_q    <= sat_d;
            if (lock_set) begin
                locked_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pop  = rec_valid && rec_ready;
    assign drop = push && fifo_full && !pop;

    count_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({period_q, sat_q}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rec_valid              = !fifo_empty;
    assign {rec_period, rec_sat}  = head;
    assign locked                 = locked_q;
    assign overflow               = overflow_q;

`ifdef COUNT_PERIOD_MONITOR_STATS_EN
    logic [PERIOD_W-1:0] min_q;
    logic [PERIOD_W-1:0] max_q;

    // Running min/max over every generated record, dropped ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (push) begin
            if (period_q < min_q) begin
                min_q <= period_q;
            end
            if (period_q > max_q) begin
                max_q <= period_q;
            end
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`endif

endmodule

// File: tb/tb_count_period_monitor.sv
// tb_count_period_monitor: randomized self-checking bench for count_period_monitor.
// Honours COUNT_PERIOD_MONITOR_STATS_EN for the optional min/max outputs.
module tb_count_period_monitor;
    import count_mon_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  count_in;
    logic        rec_valid;
    logic        rec_ready;
    logic [11:0] rec_period;
    logic        rec_sat;
    logic        locked;
    logic        overflow;

    logic        en2;
    logic [7:0]  cnt2;
    logic        v2;
    logic        ready2;
    logic [3:0]  per2;
    logic        sat2;
    logic        lock2;
    logic        ovf2;

`ifdef COUNT_PERIOD_MONITOR_STATS_EN
    logic [11:0] min_period;
    logic [11:0] max_period;
    logic [3:0]  min2;
    logic [3:0]  max2;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    rec_t        mq[$];
    bit          m_locked;
    bit          m_ovf;
    bit          seen_first;
    bit          pend;
    bit          pend_first;
    int unsigned pend_period;
    bit          m_primed;
    logic [7:0]  m_prev;
    int unsigned en_idx;
    int unsigned last_idx;
    logic [11:0] m_min;
    logic [11:0] m_max;

    // Upstream counter model (INIT..MAX, frozen while en=0).
    logic [7:0]  up_cnt;
    logic [7:0]  up_init;
    logic [7:0]  up_max;

    always #5 clk = ~clk;

    count_period_monitor #(
        .COUNT_W    (8),
        .PERIOD_W   (12),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count_in   (count_in),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_period (rec_period),
        .rec_sat    (rec_sat),
        .locked     (locked),
        .overflow   (overflow)
`ifdef COUNT_PERIOD_MONITOR_STATS_EN
        ,
        .min_period (min_period),
        .max_period (max_period)
`endif
    );

    count_period_monitor #(
        .COUNT_W    (8),
        .PERIOD_W   (4),
        .FIFO_DEPTH (DEPTH)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en2),
        .count_in   (cnt2),
        .rec_valid  (v2),
        .rec_ready  (ready2),
        .rec_period (per2),
        .rec_sat    (sat2),
        .locked     (lock2),
        .overflow   (ovf2)
`ifdef COUNT_PERIOD_MONITOR_STATS_EN
        ,
        .min_period (min2),
        .max_period (max2)
`endif
    );

    task automatic model_reset();
        mq.delete();
        m_locked    = 1'b0;
        m_ovf       = 1'b0;
        seen_first  = 1'b0;
        pend        = 1'b0;
        pend_first  = 1'b0;
        pend_period = 0;
        m_primed    = 1'b0;
        m_prev      = '0;
        en_idx      = 0;
        last_idx    = 0;
        m_min       = '1;
        m_max       = '0;
    endtask

    // Apply one cycle of inputs, advance the model across the coming edge,
    // and return at the following falling edge.
    task automatic tick(input logic e, input logic [7:0] c, input logic r);
        bit   pop;
        rec_t rec;
        en        = e;
        count_in  = c;
        rec_ready = r;
        pop = (mq.size() != 0) && r;
        if (pop) void'(mq.pop_front());
        if (pend) begin
            if (pend_first) begin
                m_locked = 1'b1;
            end else begin
                rec.sat    = (pend_period > 32'(PERIOD_MAX));
                rec.period = rec.sat ? PERIOD_MAX : pend_period[11:0];
                if (rec.period < m_min) m_min = rec.period;
                if (rec.period > m_max) m_max = rec.period;
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else mq.push_back(rec);
            end
        end
        pend = 1'b0;
        if (e) begin
            en_idx++;
            if (m_primed && c < m_prev) begin
                pend        = 1'b1;
                pend_first  = !seen_first;
                pend_period = en_idx - last_idx;
                seen_first  = 1'b1;
                last_idx    = en_idx;
            end
            m_prev = c;
        end
        m_primed = e;
        @(negedge clk);
    endtask

    task automatic upstream(input logic e, input logic r);
        tick(e, up_cnt, r);
        if (e) up_cnt = (up_cnt >= up_max) ? up_init : up_cnt + 8'd1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        count_in  = '0;
        rec_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        count_in  = '0;
        rec_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compared += 5;
        if (rec_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b required 0", rec_valid); end
        if (rec_period !== 12'd0) begin mismatched++; $display("FAIL reset_period: got %0d required 0", rec_period); end
        if (rec_sat !== 1'b0) begin mismatched++; $display("FAIL reset_sat: got %b required 0", rec_sat); end
        if (locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked: got %b required 0", locked); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b required 0", overflow); end
`ifdef COUNT_PERIOD_MONITOR_STATS_EN
        compared += 2;
        if (min_period !== 12'hfff) begin mismatched++; $display("FAIL reset_min: got %0d required 4095", min_period); end
        if (max_period !== 12'd0) begin mismatched++; $display("FAIL reset_max: got %0d required 0", max_period); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_sync();
        do_reset();
        up_init = 8'd0; up_max = 8'd99; up_cnt = 8'd0;
        for (int i = 0; i < 260; i++) begin
            compared++;
            if (rec_valid !== (mq.size() != 0) || locked !== m_locked || overflow !== m_ovf) begin
                mismatched++;
                $display("FAIL sync_flags: valid/locked/ovf=%b%b%b required %b%b%b", rec_valid, locked, overflow, mq.size() != 0, m_locked, m_ovf);
            end
            if (mq.size() != 0) begin
                compared++;
                if (rec_period !== mq[0].period || rec_sat !== mq[0].sat) begin
                    mismatched++;
                    $display("FAIL sync_head: period=%0d sat=%b required %0d %b", rec_period, rec_sat, mq[0].period, mq[0].sat);
                end
            end
            if (i == 101 || i == 102) begin
                compared++;
                if (locked !== (i == 102)) begin mismatched++; $display("FAIL sync_lock_time: cycle %0d locked=%b required %b", i, locked, i == 102); end
            end
            if (i == 201 || i == 202) begin
                compared++;
                if (rec_valid !== (i == 202)) begin mismatched++; $display("FAIL sync_latency: cycle %0d valid=%b required %b", i, rec_valid, i == 202); end
            end
            if (i == 202) begin
                compared++;
                if (rec_period !== 12'd100 || rec_sat !== 1'b0) begin mismatched++; $display("FAIL sync_first_period: got %0d/%b required 100/0", rec_period, rec_sat); end
            end
            upstream(1'b1, 1'b1);
        end
    endtask

    task automatic test_init_max();
        do_reset();
        up_init = 8'd10; up_max = 8'd100; up_cnt = 8'd10;
        for (int i = 0; i < 420; i++) begin
            compared++;
            if (rec_valid !== (mq.size() != 0) || locked !== m_locked || overflow !== m_ovf) begin
                mismatched++;
                $display("FAIL initmax_flags: valid/locked/ovf=%b%b%b required %b%b%b", rec_valid, locked, overflow, mq.size() != 0, m_locked, m_ovf);
            end
            if (rec_valid) begin
                compared++;
                if (rec_period !== 12'd91 || rec_sat !== 1'b0) begin
                    mismatched++;
                    $display("FAIL initmax_period: got %0d/%b required 91/0", rec_period, rec_sat);
                end
            end
            upstream(1'b1, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int lens[8];
        int j;
        do_reset();
        lens[0] = 5;
        for (int s = 1; s < 7; s++) lens[s] = int'($urandom_range(8, 30));
        lens[7] = 1;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < lens[s]; k++) begin
                compared++;
                if (rec_valid !== (mq.size() != 0) || overflow !== m_ovf) begin
                    mismatched++;
                    $display("FAIL bp_flags: valid/ovf=%b%b required %b%b", rec_valid, overflow, mq.size() != 0, m_ovf);
                end
                if (mq.size() != 0) begin
                    compared++;
                    if (rec_period !== mq[0].period || rec_sat !== mq[0].sat) begin
                        mismatched++;
                        $display("FAIL bp_hold: period=%0d sat=%b required %0d %b", rec_period, rec_sat, mq[0].period, mq[0].sat);
                    end
                end
                tick(1'b1, 8'(k), 1'b0);
            end
        end
        repeat (4) tick(1'b1, 8'd0, 1'b0);
        compared++;
        if (overflow !== 1'b1 || rec_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_full: ovf=%b valid=%b required 1 1", overflow, rec_valid);
        end
        j = 0;
        for (int i = 0; i < 8; i++) begin
            if (rec_valid) begin
                compared++;
                if (j >= 4 || rec_period !== 12'(lens[j + 1])) begin
                    mismatched++;
                    $display("FAIL bp_order: record %0d period=%0d required %0d", j, rec_period, (j < 4) ? lens[j + 1] : -1);
                end
                j++;
            end
            tick(1'b0, 8'd0, 1'b1);
        end
        compared++;
        if (rec_valid !== 1'b0 || j != 4) begin
            mismatched++;
            $display("FAIL bp_drain: valid=%b records=%0d required 0 4", rec_valid, j);
        end
    endtask

    task automatic test_back_to_back();
        logic r;
        do_reset();
        for (int s = 0; s < 14; s++) begin
            int len;
            len = int'($urandom_range(3, 6));
            for (int k = 0; k < len; k++) begin
                compared++;
                if (rec_valid !== (mq.size() != 0) || overflow !== m_ovf) begin
                    mismatched++;
                    $display("FAIL b2b_flags: valid/ovf=%b%b required %b%b", rec_valid, overflow, mq.size() != 0, m_ovf);
                end
                if (mq.size() != 0) begin
                    compared++;
                    if (rec_period !== mq[0].period) begin
                        mismatched++;
                        $display("FAIL b2b_head: period=%0d required %0d", rec_period, mq[0].period);
                    end
                end
                r = (mq.size() == DEPTH) ? pend : 1'b0;
                tick(1'b1, 8'(k), r);
            end
        end
        repeat (3) begin
            r = (mq.size() == DEPTH) ? pend : 1'b0;
            tick(1'b1, 8'd0, r);
        end
        compared++;
        if (overflow !== 1'b0 || rec_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_nodrop: ovf=%b valid=%b required 0 1", overflow, rec_valid);
        end
    endtask

    task automatic test_en_gating();
        int guard;
        do_reset();
        up_init = 8'd0; up_max = 8'd49; up_cnt = 8'd0;
        for (int i = 0; i < 300; i++) begin
            compared++;
            if (rec_valid !== (mq.size() != 0) || locked !== m_locked) begin
                mismatched++;
                $display("FAIL engate_flags: valid/locked=%b%b required %b%b", rec_valid, locked, mq.size() != 0, m_locked);
            end
            if (rec_valid) begin
                compared++;
                if (rec_period !== 12'd50) begin mismatched++; $display("FAIL engate_period: got %0d required 50", rec_period); end
            end
            upstream(!(i >= 120 && i < 127), 1'b1);
        end
        guard = 0;
        while (up_cnt != 8'd46 && guard < 100) begin
            upstream(1'b1, 1'b1);
            guard++;
        end
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, up_cnt, 1'b1);
            up_cnt = (up_cnt == up_max) ? up_init : up_cnt + 8'd1;
        end
        for (int i = 0; i < 160; i++) begin
            compared++;
            if (rec_valid !== (mq.size() != 0)) begin
                mismatched++;
                $display("FAIL engate_rearm: valid=%b required %b", rec_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                compared++;
                if (rec_period !== mq[0].period || rec_sat !== mq[0].sat) begin
                    mismatched++;
                    $display("FAIL engate_head: period=%0d required %0d", rec_period, mq[0].period);
                end
            end
            if (i < 4) begin
                compared++;
                if (rec_valid !== 1'b0) begin mismatched++; $display("FAIL engate_spurious: valid=%b required 0", rec_valid); end
            end
            upstream(1'b1, 1'b1);
        end
    endtask

    task automatic test_random();
        do_reset();
        up_init = 8'($urandom_range(0, 50));
        up_max  = up_init + 8'($urandom_range(5, 60));
        up_cnt  = up_init;
        for (int i = 0; i < 900; i++) begin
            compared++;
            if (rec_valid !== (mq.size() != 0) || locked !== m_locked || overflow !== m_ovf) begin
                mismatched++;
                $display("FAIL rand_flags: valid/locked/ovf=%b%b%b required %b%b%b", rec_valid, locked, overflow, mq.size() != 0, m_locked, m_ovf);
            end
            if (mq.size() != 0) begin
                compared++;
                if (rec_period !== mq[0].period || rec_sat !== mq[0].sat) begin
                    mismatched++;
                    $display("FAIL rand_head: period=%0d sat=%b required %0d %b", rec_period, rec_sat, mq[0].period, mq[0].sat);
                end
            end
            upstream(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_saturation();
        logic [7:0]  s[$];
        int          wraps[$];
        logic [3:0]  exp_p[$];
        logic        exp_s[$];
        logic [3:0]  got_p[$];
        logic        got_s[$];
        for (int rep = 0; rep < 3; rep++) for (int k = 0; k < 20; k++) s.push_back(8'(k));
        for (int k = 0; k < 5; k++) s.push_back(8'(k));
        repeat (6) s.push_back(8'd0);
        for (int i = 1; i < s.size(); i++) if (s[i] < s[i - 1]) wraps.push_back(i);
        for (int j = 1; j < wraps.size(); j++) begin
            int p;
            p = wraps[j] - wraps[j - 1];
            exp_p.push_back((p > 15) ? 4'd15 : 4'(p));
            exp_s.push_back(p > 15);
        end
        for (int i = 0; i < s.size(); i++) begin
            en2 = 1'b1; cnt2 = s[i]; ready2 = 1'b1;
            @(negedge clk);
            if (v2) begin got_p.push_back(per2); got_s.push_back(sat2); end
        end
        en2 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (v2) begin got_p.push_back(per2); got_s.push_back(sat2); end
        end
        compared++;
        if (got_p.size() != exp_p.size()) begin
            mismatched++;
            $display("FAIL sat_count: got %0d records required %0d", got_p.size(), exp_p.size());
        end
        for (int j = 0; j < exp_p.size() && j < got_p.size(); j++) begin
            compared++;
            if (got_p[j] !== exp_p[j] || got_s[j] !== exp_s[j]) begin
                mismatched++;
                $display("FAIL sat_record: #%0d got %0d/%b required %0d/%b", j, got_p[j], got_s[j], exp_p[j], exp_s[j]);
            end
        end
    endtask

`ifdef COUNT_PERIOD_MONITOR_STATS_EN
    task automatic test_stats();
        int lens[4] = '{10, 40, 25, 60};
        int emin;
        int emax;
        do_reset();
        for (int s = 0; s < 4; s++) for (int k = 0; k < lens[s]; k++) tick(1'b1, 8'(k), 1'b1);
        repeat (5) tick(1'b1, 8'd0, 1'b1);
        emin = lens[1]; emax = lens[1];
        for (int s = 2; s < 4; s++) begin
            if (lens[s] < emin) emin = lens[s];
            if (lens[s] > emax) emax = lens[s];
        end
        compared += 2;
        if (min_period !== 12'(emin) || min_period !== m_min) begin mismatched++; $display("FAIL stats_min: got %0d required %0d", min_period, emin); end
        if (max_period !== 12'(emax) || max_period !== m_max) begin mismatched++; $display("FAIL stats_max: got %0d required %0d", max_period, emax); end
    endtask
`endif

    task automatic test_reset_mid();
        int guard;
        do_reset();
        up_init = 8'd0; up_max = 8'd9; up_cnt = 8'd0;
        guard = 0;
        while (!m_ovf && guard < 200) begin
            upstream(1'b1, 1'b0);
            guard++;
        end
        repeat (2) upstream(1'b1, 1'b0);
        compared++;
        if (overflow !== 1'b1 || rec_valid !== 1'b1 || locked !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_setup: ovf/valid/locked=%b%b%b required 111", overflow, rec_valid, locked);
        end
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (rec_valid !== 1'b0 || locked !== 1'b0 || overflow !== 1'b0 || rec_period !== 12'd0 || rec_sat !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_clear: valid/locked/ovf=%b%b%b period=%0d sat=%b required 000 0 0", rec_valid, locked, overflow, rec_period, rec_sat);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        en2    = 1'b0;
        cnt2   = '0;
        ready2 = 1'b0;
        test_reset();
        test_sync();
        test_init_max();
        test_backpressure();
        test_back_to_back();
        test_en_gating();
        test_random();
        test_saturation();
`ifdef COUNT_PERIOD_MONITOR_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
